// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array weight path.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wf_state_e;

  localparam int WF_FIFO_DEPTH = 2;

  // Address width for a RAM of the given word count (never zero).
  function automatic int addr_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry registered FIFO between the weight RAM and the systolic array.
module weight_skid_fifo #(
  parameter int width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [width-1:0] data_i,
  input  logic             pop_i,
  output logic [width-1:0] data_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [1:0][width-1:0] mem_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && (count_q != 2'd2);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (!do_push && do_pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; count_q alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/weight_fetch.sv
// Streams a contiguous (wrapping) range of weight RAM words to the systolic array.
// Optional backpressure counter enabled by defining WEIGHT_FETCH_STALL_CNT_EN.
module weight_fetch
  import systolic_pkg::*;
#(
  parameter  int width = 32,
  parameter  int depth = 256,
  localparam int AW    = addr_w(depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [AW-1:0]    base_addr_i,
  input  logic [AW:0]      len_i,
  output logic [AW-1:0]    ram_addr_rd_o,
  output logic             ram_rd_en_o,
  input  logic [width-1:0] ram_data_i,
  output logic [width-1:0] w_data_o,
  output logic             w_valid_o,
  input  logic             w_ready_i,
  output logic             w_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      stall_cnt_o
);

  wf_state_e     state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, addr_inc;
  logic [AW:0]   rd_rem_q, rd_rem_d;
  logic [AW:0]   out_rem_q, out_rem_d;
  logic          inflight_q;

  logic [1:0]    fifo_cnt;
  logic          fifo_valid;
  logic [width-1:0] fifo_data;
  logic          pop, issue;
  logic [2:0]    credit;

  assign pop = fifo_valid && w_ready_i;

  // A slot freed by this cycle's pop is usable: the read lands two edges later.
  assign credit = 3'd2 - {1'b0, fifo_cnt} + {2'b0, pop};
  assign issue  = (state_q == FETCH) && (credit > {2'b0, inflight_q});

  assign addr_inc = (addr_q == AW'(depth - 1)) ? '0 : addr_q + AW'(1);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rd_rem_d  = rd_rem_q;
    out_rem_d = out_rem_q;
    if (pop) out_rem_d = out_rem_q - (AW+1)'(1);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d    = base_addr_i;
          rd_rem_d  = len_i;
          out_rem_d = len_i;
          state_d   = (len_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue) begin
          addr_d   = addr_inc;
          rd_rem_d = rd_rem_q - (AW+1)'(1);
          if (rd_rem_q == (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_rem_q == (AW+1)'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_rem_q   <= '0;
      out_rem_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_rem_q   <= rd_rem_d;
      out_rem_q  <= out_rem_d;
      inflight_q <= issue;
    end
  end

  weight_skid_fifo #(.width(width)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight_q),
    .data_i  (ram_data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign ram_addr_rd_o = addr_q;
  assign ram_rd_en_o   = issue;
  assign w_data_o      = fifo_data;
  assign w_valid_o     = fifo_valid;
  assign w_last_o      = fifo_valid && (out_rem_q == (AW+1)'(1));
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);

`ifdef WEIGHT_FETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start_i)
      stall_d = '0;
    else if (fifo_valid && !w_ready_i && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
